// File: rtl/t02_pc_unit.sv
// Program counter / next-PC stage for the team_02 RV32I core: IDLE/FETCH/EXECUTE sequencing,
// branch and jump resolution from the ALU result. Optional trap on misaligned targets: T02_MISALIGN_TRAP_EN.
module t02_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h3300_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ack,
  input  logic        dmem_busy,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_req,
  output logic        exec_en,
  output logic        taken,
  output logic        misalign
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FETCH = 2'b01;
  localparam logic [1:0] S_EXEC  = 2'b10;

  logic [1:0]  state;
  logic        cond;
  logic        redirect;
  logic        bad_target;
  logic        mis_q;
  logic [31:0] npc_raw;
  logic [31:0] npc;

  assign pc_plus4  = pc + 32'd4;
  assign fetch_req = (state == S_FETCH);
  assign exec_en   = (state == S_EXEC);
  assign misalign  = mis_q;

  // BLT/BGE use the ALU's SLT bit; unsigned compares are never taken.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = alu_zero;
      3'b001:  cond = !alu_zero;
      3'b100:  cond = alu_result[0];
      3'b101:  cond = !alu_result[0];
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    redirect = is_jalr | is_jal | (is_branch & cond);
    if (is_jalr)       npc_raw = {alu_result[31:1], 1'b0};
    else if (redirect) npc_raw = pc + imm;
    else               npc_raw = pc_plus4;
  end

`ifdef T02_MISALIGN_TRAP_EN
  assign bad_target = |npc_raw[1:0];
  assign npc        = npc_raw;
`else
  assign bad_target = 1'b0;
  assign npc        = npc_raw & ~32'd3;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= S_IDLE;
      taken <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      case (state)
        // A trapped core parks here until reset.
        S_IDLE:  if (!mis_q) state <= S_FETCH;
        S_FETCH: if (imem_ack) state <= S_EXEC;
        S_EXEC: begin
          if (!dmem_busy) begin
            if (bad_target) begin
              mis_q <= 1'b1;
              state <= S_IDLE;
            end else begin
              pc    <= npc;
              taken <= redirect;
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
